// File: rtl/rr_grant_scheduler_pkg.sv
// +----------------------------------------------------------------------+
// | rr_grant_scheduler_pkg: shared FSM encoding and index helpers        |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

package rr_grant_scheduler_pkg;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Next index after idx, wrapping to 0 at n (non-power-of-2 safe).
  function automatic int wrap_inc(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/rr_grant_scheduler_demux.sv
// +----------------------------------------------------------------------+
// | rr_grant_scheduler_demux: select index to one-hot output decoder     |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module rr_grant_scheduler_demux
  import rr_grant_scheduler_pkg::*;
#(
  parameter int NUM_OUTPUTS = 5
) (
  input  logic [idx_width(NUM_OUTPUTS)-1:0] i_select,
  output logic [NUM_OUTPUTS-1:0]            o_output
);

  localparam int SEL_W = idx_width(NUM_OUTPUTS);

  for (genvar g = 0; g < NUM_OUTPUTS; g++) begin : g_out
    assign o_output[g] = (i_select == SEL_W'(g));
  end

endmodule

`default_nettype wire

// File: rtl/rr_grant_scheduler.sv
// +----------------------------------------------------------------------+
// | rr_grant_scheduler: round-robin single-grant scheduler with hold     |
// | limit; grant vector decoded from the registered select index.        |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module rr_grant_scheduler
  import rr_grant_scheduler_pkg::*;
#(
  parameter int NUM_REQ  = 5,
  parameter int MAX_HOLD = 8
) (
  input  logic                          i_clk,
  input  logic                          i_rst_n,
  input  logic [NUM_REQ-1:0]            i_req,
  input  logic                          i_release,
  output logic [NUM_REQ-1:0]            o_grant,
  output logic [idx_width(NUM_REQ)-1:0] o_grant_idx,
  output logic                          o_busy,
  output logic                          o_timeout
);

  localparam int IDX_W = idx_width(NUM_REQ);
  localparam int CNT_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam logic [CNT_W-1:0] c_HOLD_LAST = CNT_W'((MAX_HOLD > 0) ? MAX_HOLD - 1 : 0);

  state_t             r_state;
  logic [IDX_W-1:0]   r_idx;
  logic [IDX_W-1:0]   r_ptr;
  logic [CNT_W-1:0]   r_hold;
  logic               r_timeout;

  logic [IDX_W-1:0]   w_winner;
  int                 w_pos;
  logic               w_normal_rel;
  logic               w_limit;
  logic               w_release;
  logic [NUM_REQ-1:0] w_onehot;

  // Scan downward in priority so the lowest offset from the pointer wins last.
  always_comb begin
    w_winner = r_ptr;
    w_pos    = 0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      w_pos = int'(r_ptr) + k;
      if (w_pos >= NUM_REQ) w_pos = w_pos - NUM_REQ;
      if (i_req[IDX_W'(w_pos)]) w_winner = IDX_W'(w_pos);
    end
  end

  assign w_normal_rel = i_release | ~i_req[r_idx];
  assign w_limit      = (MAX_HOLD != 0) && (r_hold == c_HOLD_LAST);
  assign w_release    = w_normal_rel | w_limit;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= ST_IDLE;
      r_idx     <= '0;
      r_ptr     <= '0;
      r_hold    <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_timeout <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (|i_req) begin
            r_idx   <= w_winner;
            r_state <= ST_BUSY;
            r_hold  <= '0;
          end
        end
        ST_BUSY: begin
          if (w_release) begin
            r_state   <= ST_IDLE;
            r_ptr     <= IDX_W'(wrap_inc(int'(r_idx), NUM_REQ));
            r_hold    <= '0;
            // A coincident release or withdrawal makes this a normal release.
            r_timeout <= w_limit & ~w_normal_rel;
          end else if (r_hold != c_HOLD_LAST) begin
            r_hold <= r_hold + 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  rr_grant_scheduler_demux #(
    .NUM_OUTPUTS (NUM_REQ)
  ) u_demux (
    .i_select (r_idx),
    .o_output (w_onehot)
  );

  assign o_busy      = (r_state == ST_BUSY);
  assign o_grant     = o_busy ? w_onehot : '0;
  assign o_grant_idx = r_idx;
  assign o_timeout   = r_timeout;

endmodule

`default_nettype wire

// File: tb/tb_rr_grant_scheduler.sv
// +----------------------------------------------------------------------+
// | tb_rr_grant_scheduler: directed self-checking bench                  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_rr_grant_scheduler;

  logic       i_clk;
  logic       i_rst_n;
  logic [4:0] i_req;
  logic       i_release;
  logic [4:0] o_grant;
  logic [2:0] o_grant_idx;
  logic       o_busy;
  logic       o_timeout;

  int n_vec;
  int n_err;

  // {busy, timeout, idx, grant}
  logic [9:0] w_obs;
  assign w_obs = {o_busy, o_timeout, o_grant_idx, o_grant};

  rr_grant_scheduler #(
    .NUM_REQ  (5),
    .MAX_HOLD (8)
  ) dut (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_req       (i_req),
    .i_release   (i_release),
    .o_grant     (o_grant),
    .o_grant_idx (o_grant_idx),
    .o_busy      (o_busy),
    .o_timeout   (o_timeout)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  function automatic logic [9:0] exp_grant(input logic [2:0] idx);
    logic [4:0] oh;
    oh = 5'b00001 << idx;
    return {1'b1, 1'b0, idx, oh};
  endfunction

  function automatic logic [9:0] exp_idle(input logic [2:0] idx, input logic tmo);
    return {1'b0, tmo, idx, 5'b00000};
  endfunction

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic test_reset();
    i_rst_n   = 1'b0;
    i_req     = 5'b11111;
    i_release = 1'b0;
    #3;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_vec++;
      if (w_obs !== 10'd0) begin
        n_err++;
        $display("FAIL reset_hold cyc%0d: got %b expected %b", i, w_obs, 10'd0);
      end
    end
    i_rst_n = 1'b1;
    tick();
    n_vec++;
    if (w_obs !== exp_grant(3'd0)) begin
      n_err++;
      $display("FAIL reset_first_grant: got %b expected %b", w_obs, exp_grant(3'd0));
    end
    i_req = 5'b00000;
    tick();
    n_vec++;
    if (w_obs !== exp_idle(3'd0, 1'b0)) begin
      n_err++;
      $display("FAIL reset_withdraw: got %b expected %b", w_obs, exp_idle(3'd0, 1'b0));
    end
  endtask

  task automatic test_round_robin();
    logic [2:0] order [5];
    order[0] = 3'd1; order[1] = 3'd2; order[2] = 3'd4; order[3] = 3'd1; order[4] = 3'd2;
    i_req = 5'b10110;
    for (int n = 0; n < 5; n++) begin
      tick();
      n_vec++;
      if (w_obs !== exp_grant(order[n])) begin
        n_err++;
        $display("FAIL rr_grant%0d: got %b expected %b", n, w_obs, exp_grant(order[n]));
      end
      tick();
      n_vec++;
      if (w_obs !== exp_grant(order[n])) begin
        n_err++;
        $display("FAIL rr_hold%0d: got %b expected %b", n, w_obs, exp_grant(order[n]));
      end
      i_release = 1'b1;
      tick();
      i_release = 1'b0;
      n_vec++;
      if (w_obs !== exp_idle(order[n], 1'b0)) begin
        n_err++;
        $display("FAIL rr_idle%0d: got %b expected %b", n, w_obs, exp_idle(order[n], 1'b0));
      end
    end
  endtask

  task automatic test_wrap();
    i_req = 5'b10000;
    tick();
    n_vec++;
    if (w_obs !== exp_grant(3'd4)) begin
      n_err++;
      $display("FAIL wrap_grant4: got %b expected %b", w_obs, exp_grant(3'd4));
    end
    i_release = 1'b1;
    i_req     = 5'b10001;
    tick();
    i_release = 1'b0;
    n_vec++;
    if (w_obs !== exp_idle(3'd4, 1'b0)) begin
      n_err++;
      $display("FAIL wrap_idle: got %b expected %b", w_obs, exp_idle(3'd4, 1'b0));
    end
    tick();
    n_vec++;
    if (w_obs !== exp_grant(3'd0)) begin
      n_err++;
      $display("FAIL wrap_grant0: got %b expected %b", w_obs, exp_grant(3'd0));
    end
    i_req = 5'b00000;
    tick();
  endtask

  task automatic test_timeout();
    i_req = 5'b00100;
    for (int i = 0; i < 8; i++) begin
      tick();
      n_vec++;
      if (w_obs !== exp_grant(3'd2)) begin
        n_err++;
        $display("FAIL tmo_hold%0d: got %b expected %b", i, w_obs, exp_grant(3'd2));
      end
    end
    tick();
    n_vec++;
    if (w_obs !== exp_idle(3'd2, 1'b1)) begin
      n_err++;
      $display("FAIL tmo_pulse: got %b expected %b", w_obs, exp_idle(3'd2, 1'b1));
    end
    tick();
    n_vec++;
    if (w_obs !== exp_grant(3'd2)) begin
      n_err++;
      $display("FAIL tmo_regrant: got %b expected %b", w_obs, exp_grant(3'd2));
    end
    i_req = 5'b00000;
    tick();
    n_vec++;
    if (w_obs !== exp_idle(3'd2, 1'b0)) begin
      n_err++;
      $display("FAIL tmo_drop: got %b expected %b", w_obs, exp_idle(3'd2, 1'b0));
    end
  endtask

  task automatic test_withdraw_collision();
    i_req = 5'b01000;
    tick();
    tick();
    n_vec++;
    if (w_obs !== exp_grant(3'd3)) begin
      n_err++;
      $display("FAIL wd_grant3: got %b expected %b", w_obs, exp_grant(3'd3));
    end
    i_req = 5'b00000;
    tick();
    n_vec++;
    if (w_obs !== exp_idle(3'd3, 1'b0)) begin
      n_err++;
      $display("FAIL wd_release: got %b expected %b", w_obs, exp_idle(3'd3, 1'b0));
    end
    i_req = 5'b11111;
    tick();
    n_vec++;
    if (w_obs !== exp_grant(3'd4)) begin
      n_err++;
      $display("FAIL wd_ptr4: got %b expected %b", w_obs, exp_grant(3'd4));
    end
    for (int i = 0; i < 7; i++) tick();
    n_vec++;
    if (w_obs !== exp_grant(3'd4)) begin
      n_err++;
      $display("FAIL col_pre: got %b expected %b", w_obs, exp_grant(3'd4));
    end
    i_release = 1'b1;
    tick();
    i_release = 1'b0;
    n_vec++;
    if (w_obs !== exp_idle(3'd4, 1'b0)) begin
      n_err++;
      $display("FAIL col_no_tmo: got %b expected %b", w_obs, exp_idle(3'd4, 1'b0));
    end
    tick();
    n_vec++;
    if (w_obs !== exp_grant(3'd0)) begin
      n_err++;
      $display("FAIL col_regrant: got %b expected %b", w_obs, exp_grant(3'd0));
    end
  endtask

  task automatic test_async_reset();
    i_req = 5'b00000;
    tick();
    i_req = 5'b01000;
    tick();
    n_vec++;
    if (w_obs !== exp_grant(3'd3)) begin
      n_err++;
      $display("FAIL ar_grant3: got %b expected %b", w_obs, exp_grant(3'd3));
    end
    #2;
    i_rst_n = 1'b0;
    #1;
    n_vec++;
    if (w_obs !== 10'd0) begin
      n_err++;
      $display("FAIL ar_immediate: got %b expected %b", w_obs, 10'd0);
    end
    i_req = 5'b01001;
    tick();
    i_rst_n = 1'b1;
    tick();
    n_vec++;
    if (w_obs !== exp_grant(3'd0)) begin
      n_err++;
      $display("FAIL ar_after: got %b expected %b", w_obs, exp_grant(3'd0));
    end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    test_reset();
    test_round_robin();
    test_wrap();
    test_timeout();
    test_withdraw_collision();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
